// File: rtl/xadc_pkg.sv
// Shared definitions for the XADC DRP scan reader: status register
// addresses, FSM state encoding and channel-address table lookup.
// Pure declarations; no timing or flow-control behaviour of its own.
package xadc_pkg;

    // DRP status register addresses
    localparam logic [6:0] ADDR_TEMP  = 7'h00;
    localparam logic [6:0] ADDR_VAUX6 = 7'h16;
    localparam logic [6:0] ADDR_VAUX7 = 7'h17;

    // Upper bound on channels per scan; sizes the address-table argument
    localparam int MAX_CH = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_OUT
    } state_e;

    // Entry k of a packed 7-bit address table (entry 0 in the LSBs).
    // Callers zero-extend their table to MAX_CH entries.
    function automatic logic [6:0] ch_addr(input logic [7*MAX_CH-1:0] tbl,
                                           input logic [31:0]         k);
        return tbl[7*k +: 7];
    endfunction

endpackage

// File: rtl/xadc_scan_reader.sv
// Purpose : on each eoc pulse, DRP-read NUM_CH status registers in order,
//           average each over 2^AVG_LOG2 scans and stream results out.
// Latency : eoc -> den 1 cycle; final-scan drdy -> valid_o 1 cycle;
//           ready_i -> next den 1 cycle.
// Backpr. : valid_o/data_o/ch_o hold while ready_i=0; no further DRP
//           request is issued until the result is accepted.
//
// Ports:
//   clk_i, reset_ni          DRP clock, async active-low reset
//   eoc_i                    end-of-conversion, starts a scan when idle
//   drp_den_o/drp_daddr_o    DRP read request (den is a 1-cycle pulse)
//   drp_drdy_i/drp_do_i      DRP read response
//   data_o/ch_o/valid_o/ready_i   result stream
//   busy_o                   scan in progress
//   overrun_o                sticky: eoc arrived while busy
//   timeout_o                1-cycle pulse when the DRP fails to answer
module xadc_scan_reader
    import xadc_pkg::*;
#(
    parameter int                  NUM_CH    = 2,
    parameter logic [7*NUM_CH-1:0] CH_ADDR   = {7'h17, 7'h16},
    parameter int                  ADC_WIDTH = 12,
    parameter int                  AVG_LOG2  = 0,
    parameter int                  TIMEOUT   = 64,
    localparam int                 CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 eoc_i,
    output logic                 drp_den_o,
    output logic [6:0]           drp_daddr_o,
    input  logic                 drp_drdy_i,
    input  logic [15:0]          drp_do_i,
    output logic [ADC_WIDTH-1:0] data_o,
    output logic [CH_W-1:0]      ch_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 busy_o,
    output logic                 overrun_o,
    output logic                 timeout_o
);

    localparam int ACC_W  = ADC_WIDTH + AVG_LOG2;
    localparam int SCAN_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int TMO_W  = $clog2(TIMEOUT);

    localparam logic [CH_W-1:0]     CH_LAST   = CH_W'(NUM_CH - 1);
    localparam logic [SCAN_W-1:0]   SCAN_LAST = SCAN_W'((1 << AVG_LOG2) - 1);
    localparam logic [TMO_W-1:0]    TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [7*MAX_CH-1:0] ADDR_TBL  = (7*MAX_CH)'(CH_ADDR);

    state_e                state_q, state_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [SCAN_W-1:0]     scan_q, scan_d;
    logic [ACC_W-1:0]      acc_q [NUM_CH];
    logic [ACC_W-1:0]      acc_d [NUM_CH];
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [ADC_WIDTH-1:0]  data_q, data_d;
    logic [CH_W-1:0]       cho_q, cho_d;
    logic [6:0]            daddr_q, daddr_d;
    logic                  overrun_q, overrun_d;

    logic                  tmo_pulse;
    logic [ADC_WIDTH-1:0]  sample;
    logic [ACC_W-1:0]      acc_sel;
    logic [ACC_W-1:0]      sum;
    logic [6:0]            cur_addr;
    logic                  unused_do;

    // Result is the top ADC_WIDTH bits of the DRP word; the low bits are
    // intentionally discarded.
    assign sample    = drp_do_i[15 -: ADC_WIDTH];
    assign unused_do = ^drp_do_i;

    assign cur_addr = ch_addr(ADDR_TBL, {{(32-CH_W){1'b0}}, ch_q});

    // Accumulator of the channel being read. Width ACC_W cannot overflow:
    // at most 2^AVG_LOG2 samples of ADC_WIDTH bits are summed.
    always_comb begin
        acc_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_q == CH_W'(k)) begin
                acc_sel = acc_q[k];
            end
        end
    end

    assign sum = acc_sel + ACC_W'(sample);

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        scan_d    = scan_q;
        acc_d     = acc_q;
        tmo_d     = tmo_q;
        data_d    = data_q;
        cho_d     = cho_q;
        daddr_d   = daddr_q;
        overrun_d = overrun_q | (eoc_i && (state_q != ST_IDLE));
        tmo_pulse = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (eoc_i) begin
                    ch_d    = '0;
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                daddr_d = cur_addr;
                tmo_d   = '0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (drp_drdy_i) begin
                    if (scan_q != SCAN_LAST) begin
                        // Intermediate scan: fold sample into accumulator
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (ch_q == CH_W'(k)) begin
                                acc_d[k] = sum;
                            end
                        end
                        if (ch_q == CH_LAST) begin
                            scan_d  = scan_q + 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            ch_d    = ch_q + 1'b1;
                            state_d = ST_REQ;
                        end
                    end else begin
                        // Final scan: emit average, free accumulator
                        data_d = sum[AVG_LOG2 +: ADC_WIDTH];
                        cho_d  = ch_q;
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (ch_q == CH_W'(k)) begin
                                acc_d[k] = '0;
                            end
                        end
                        state_d = ST_OUT;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // DRP never answered: drop the whole averaging window
                    tmo_pulse = 1'b1;
                    for (int k = 0; k < NUM_CH; k++) begin
                        acc_d[k] = '0;
                    end
                    scan_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            ST_OUT: begin
                if (ready_i) begin
                    if (ch_q == CH_LAST) begin
                        scan_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        ch_d    = ch_q + 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            scan_q    <= '0;
            tmo_q     <= '0;
            data_q    <= '0;
            cho_q     <= '0;
            daddr_q   <= '0;
            overrun_q <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            scan_q    <= scan_d;
            tmo_q     <= tmo_d;
            data_q    <= data_d;
            cho_q     <= cho_d;
            daddr_q   <= daddr_d;
            overrun_q <= overrun_d;
            acc_q     <= acc_d;
        end
    end

    // Address is driven live during REQ and then held by daddr_q.
    assign drp_den_o   = (state_q == ST_REQ);
    assign drp_daddr_o = (state_q == ST_REQ) ? cur_addr : daddr_q;
    assign valid_o     = (state_q == ST_OUT);
    assign busy_o      = (state_q != ST_IDLE);
    assign data_o      = data_q;
    assign ch_o        = cho_q;
    assign overrun_o   = overrun_q;
    assign timeout_o   = tmo_pulse;

endmodule

// File: tb/tb_xadc_scan_reader.sv
// Bench for xadc_scan_reader: two instances (no averaging / 4-scan
// averaging) driven by a behavioural DRP responder, with an output
// monitor and a sample-sum reference model for randomized scans.
module tb_xadc_scan_reader;
    import xadc_pkg::*;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        eoc   [2];
    logic        drdy  [2];
    logic [15:0] dout  [2];
    logic        rdy   [2];
    logic        den   [2];
    logic [6:0]  daddr [2];
    logic [11:0] data  [2];
    logic        ch    [2];
    logic        vld   [2];
    logic        busy  [2];
    logic        ovr   [2];
    logic        tmo   [2];

    xadc_scan_reader #(
        .NUM_CH(2), .CH_ADDR({ADDR_VAUX7, ADDR_VAUX6}), .ADC_WIDTH(12),
        .AVG_LOG2(0), .TIMEOUT(64)
    ) u_dut0 (
        .clk_i(clk), .reset_ni(rst_n[0]), .eoc_i(eoc[0]),
        .drp_den_o(den[0]), .drp_daddr_o(daddr[0]),
        .drp_drdy_i(drdy[0]), .drp_do_i(dout[0]),
        .data_o(data[0]), .ch_o(ch[0]), .valid_o(vld[0]), .ready_i(rdy[0]),
        .busy_o(busy[0]), .overrun_o(ovr[0]), .timeout_o(tmo[0])
    );

    xadc_scan_reader #(
        .NUM_CH(2), .CH_ADDR({ADDR_VAUX7, ADDR_VAUX6}), .ADC_WIDTH(12),
        .AVG_LOG2(2), .TIMEOUT(8)
    ) u_dut1 (
        .clk_i(clk), .reset_ni(rst_n[1]), .eoc_i(eoc[1]),
        .drp_den_o(den[1]), .drp_daddr_o(daddr[1]),
        .drp_drdy_i(drdy[1]), .drp_do_i(dout[1]),
        .data_o(data[1]), .ch_o(ch[1]), .valid_o(vld[1]), .ready_i(rdy[1]),
        .busy_o(busy[1]), .overrun_o(ovr[1]), .timeout_o(tmo[1])
    );

    int          n_tests;
    int          n_fail;
    int          cyc;
    logic [15:0] resp_q   [2][$];
    int          lat      [2];
    logic        rand_rdy [2];
    logic [12:0] got_q    [2][$];
    int          den_cyc  [2][$];
    logic [6:0]  addr_log [2][$];
    int          drdy_cyc [2][$];
    int          vld_cyc  [2][$];
    int          tmo_cyc  [2][$];
    int          vld_cnt  [2];
    logic [12:0] exp_q[$];

    typedef struct packed {
        logic [15:0] w0;
        logic [15:0] w1;
        logic [11:0] e0;
        logic [11:0] e1;
    } vec_t;
    vec_t vecs [5];

    always @(posedge clk) cyc <= cyc + 1;

    // Output/DRP monitor, mid-cycle
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (den[i]) begin
                den_cyc[i].push_back(cyc);
                addr_log[i].push_back(daddr[i]);
            end
            if (vld[i]) begin
                vld_cnt[i]++;
                vld_cyc[i].push_back(cyc);
                if (rdy[i]) got_q[i].push_back({ch[i], data[i]});
            end
            if (tmo[i]) tmo_cyc[i].push_back(cyc);
        end
    end

    // Random downstream backpressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++)
                if (rand_rdy[i]) rdy[i] = 1'($urandom_range(0, 1));
        end
    end

    // DRP model: answers each den lat cycles later with the next queued
    // word; an empty queue means the DRP never answers.
    task automatic responder(input int i);
        logic        pulsing;
        logic [15:0] w;
        pulsing = 1'b0;
        forever begin
            @(negedge clk);
            if (pulsing) begin
                drdy[i] = 1'b0;
                pulsing = 1'b0;
            end
            if (den[i] && resp_q[i].size() > 0) begin
                w = resp_q[i].pop_front();
                repeat (lat[i]) @(negedge clk);
                drdy_cyc[i].push_back(cyc);
                dout[i] = w;
                drdy[i] = 1'b1;
                pulsing = 1'b1;
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int at(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -1000;
    endfunction

    function automatic logic [12:0] got_at(input int i, input int k);
        return (k < got_q[i].size()) ? got_q[i][k] : 13'h1FFF;
    endfunction

    task automatic clear_logs(input int i);
        got_q[i].delete();
        den_cyc[i].delete();
        addr_log[i].delete();
        drdy_cyc[i].delete();
        vld_cyc[i].delete();
        tmo_cyc[i].delete();
        vld_cnt[i] = 0;
    endtask

    task automatic pulse_eoc(input int i);
        eoc[i] = 1'b1;
        tick(1);
        eoc[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input string nm);
        int n;
        n = 0;
        while (busy[i] && n < 1000) begin
            tick(1);
            n++;
        end
        check(nm, busy[i], 1'b0);
    endtask

    task automatic check_zero(input int i, input string nm);
        check({nm, "_valid"}, vld[i], 1'b0);
        check({nm, "_den"}, den[i], 1'b0);
        check({nm, "_busy"}, busy[i], 1'b0);
        check({nm, "_overrun"}, ovr[i], 1'b0);
        check({nm, "_timeout"}, tmo[i], 1'b0);
        check({nm, "_data"}, data[i], 12'h000);
        check({nm, "_ch"}, ch[i], 1'b0);
        check({nm, "_daddr"}, daddr[i], ADDR_TEMP);
    endtask

    task automatic one_scan(input int i, input logic [15:0] w0, input logic [15:0] w1);
        resp_q[i].push_back(w0);
        resp_q[i].push_back(w1);
        pulse_eoc(i);
        wait_idle(i, "scan_done");
    endtask

    initial begin
        int          t, n, nden, nsc, per;
        logic [11:0] d0;
        logic        c0, stable;
        logic [15:0] w;
        int          sums [2];

        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; eoc[i] = 1'b0; drdy[i] = 1'b0; dout[i] = 16'h0;
            rdy[i] = 1'b1; rand_rdy[i] = 1'b0; lat[i] = 3;
            resp_q[i].delete();
            clear_logs(i);
        end
        vecs[0] = '{16'h1000, 16'hFFF0, 12'h100, 12'hFFF};
        vecs[1] = '{16'h0000, 16'hFFFF, 12'h000, 12'hFFF};
        vecs[2] = '{16'h800F, 16'h7FF1, 12'h800, 12'h7FF};
        vecs[3] = '{16'h5A5A, 16'hA5A5, 12'h5A5, 12'hA5A};
        vecs[4] = '{16'h0010, 16'hFFE0, 12'h001, 12'hFFE};

        fork
            responder(0);
            responder(1);
        join_none

        // Reset state
        tick(3);
        check_zero(0, "rst0");
        check_zero(1, "rst1");
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        tick(2);

        // First-transaction timing, ready held high
        clear_logs(0);
        resp_q[0].push_back(16'hABC0);
        resp_q[0].push_back(16'h1234);
        t = cyc;
        pulse_eoc(0);
        wait_idle(0, "tim_done");
        check("tim_den_cnt", den_cyc[0].size(), 2);
        check("tim_eoc_to_den", at(den_cyc[0], 0) - t, 1);
        check("tim_addr0", addr_log[0].size() > 0 ? addr_log[0][0] : 7'h7F, ADDR_VAUX6);
        check("tim_addr1", addr_log[0].size() > 1 ? addr_log[0][1] : 7'h7F, ADDR_VAUX7);
        check("tim_drdy_to_valid", at(vld_cyc[0], 0) - at(drdy_cyc[0], 0), 1);
        check("tim_ready_to_den", at(den_cyc[0], 1) - at(vld_cyc[0], 0), 1);
        check("tim_valid_cycles", vld_cnt[0], 2);
        check("tim_res0", got_at(0, 0), {1'b0, 12'hABC});
        check("tim_res1", got_at(0, 1), {1'b1, 12'h123});

        // Table of single scans without averaging
        for (int v = 0; v < 5; v++) begin
            clear_logs(0);
            one_scan(0, vecs[v].w0, vecs[v].w1);
            check("vec_cnt", got_q[0].size(), 2);
            check("vec_ch0", got_at(0, 0), {1'b0, vecs[v].e0});
            check("vec_ch1", got_at(0, 1), {1'b1, vecs[v].e1});
        end

        // Four-scan averaging
        clear_logs(1);
        for (int s = 0; s < 4; s++) begin
            one_scan(1, 16'((12'h100 + 12'(2 * s)) << 4), 16'(s << 4));
            if (s < 3) check("avg_no_valid_early", vld_cnt[1], 0);
        end
        check("avg_cnt", got_q[1].size(), 2);
        check("avg_ch0", got_at(1, 0), {1'b0, 12'h103});
        check("avg_ch1", got_at(1, 1), {1'b1, 12'h001});
        clear_logs(1);
        one_scan(1, 16'hFFF0, 16'h0010);
        one_scan(1, 16'hFFF0, 16'h0000);
        one_scan(1, 16'hFFF0, 16'h0000);
        one_scan(1, 16'hFFF0, 16'h0000);
        check("avg2_ch0", got_at(1, 0), {1'b0, 12'hFFF});
        check("avg2_ch1", got_at(1, 1), {1'b1, 12'h000});

        // Backpressure with eoc during the stall
        clear_logs(0);
        rdy[0] = 1'b0;
        resp_q[0].push_back(16'h4440);
        resp_q[0].push_back(16'h5550);
        pulse_eoc(0);
        n = 0;
        while (!vld[0] && n < 50) begin
            tick(1);
            n++;
        end
        check("bp_valid", vld[0], 1'b1);
        d0 = data[0];
        c0 = ch[0];
        nden = den_cyc[0].size();
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            eoc[0] = (k == 4);
            tick(1);
            if (!vld[0] || data[0] !== d0 || ch[0] !== c0) stable = 1'b0;
        end
        eoc[0] = 1'b0;
        check("bp_stable", stable, 1'b1);
        check("bp_data", d0, 12'h444);
        check("bp_no_den", den_cyc[0].size(), nden);
        check("bp_overrun", ovr[0], 1'b1);
        rdy[0] = 1'b1;
        wait_idle(0, "bp_done");
        check("bp_overrun_sticky", ovr[0], 1'b1);
        check("bp_den_total", den_cyc[0].size(), 2);
        check("bp_res1", got_at(0, 1), {1'b1, 12'h555});

        // DRP timeout, then a clean scan
        clear_logs(0);
        pulse_eoc(0);
        wait_idle(0, "tmo_done");
        check("tmo_cnt", tmo_cyc[0].size(), 1);
        check("tmo_delay", at(tmo_cyc[0], 0) - at(den_cyc[0], 0), 64);
        check("tmo_no_valid", vld_cnt[0], 0);
        clear_logs(0);
        one_scan(0, 16'h1230, 16'h4560);
        check("tmo_next0", got_at(0, 0), {1'b0, 12'h123});
        check("tmo_next1", got_at(0, 1), {1'b1, 12'h456});

        // Timeout mid-window discards the partial average
        clear_logs(1);
        one_scan(1, 16'hFFF0, 16'hFFF0);
        one_scan(1, 16'hFFF0, 16'hFFF0);
        resp_q[1].push_back(16'hFFF0);
        pulse_eoc(1);
        wait_idle(1, "tmo1_done");
        check("tmo1_cnt", tmo_cyc[1].size(), 1);
        one_scan(1, 16'h0100, 16'h0080);
        one_scan(1, 16'h0200, 16'h0080);
        one_scan(1, 16'h0300, 16'h0080);
        one_scan(1, 16'h0400, 16'h0080);
        check("tmo1_cnt_out", got_q[1].size(), 2);
        check("tmo1_ch0", got_at(1, 0), {1'b0, 12'h028});
        check("tmo1_ch1", got_at(1, 1), {1'b1, 12'h008});

        // Stray drdy while idle
        clear_logs(0);
        @(negedge clk);
        dout[0] = 16'hFFFF;
        drdy[0] = 1'b1;
        @(negedge clk);
        drdy[0] = 1'b0;
        tick(4);
        check("stray_no_valid", vld_cnt[0], 0);
        check("stray_idle", busy[0], 1'b0);

        // Randomized scans against a sum/average model
        for (int i = 0; i < 2; i++) begin
            nsc = (i == 0) ? 24 : 12;
            per = (i == 0) ? 1 : 4;
            clear_logs(i);
            exp_q.delete();
            sums[0] = 0;
            sums[1] = 0;
            rand_rdy[i] = 1'b1;
            for (int s = 0; s < nsc; s++) begin
                for (int c = 0; c < 2; c++) begin
                    w = 16'($urandom);
                    resp_q[i].push_back(w);
                    sums[c] += int'(w[15:4]);
                end
                lat[i] = $urandom_range(1, 6);
                pulse_eoc(i);
                wait_idle(i, "rnd_done");
                if ((s + 1) % per == 0) begin
                    for (int c = 0; c < 2; c++) begin
                        exp_q.push_back({c[0], 12'(sums[c] / per)});
                        sums[c] = 0;
                    end
                end
            end
            rand_rdy[i] = 1'b0;
            tick(1);
            rdy[i] = 1'b1;
            lat[i] = 3;
            check("rnd_cnt", got_q[i].size(), exp_q.size());
            for (int k = 0; k < exp_q.size(); k++)
                check("rnd_res", got_at(i, k), exp_q[k]);
        end

        // Asynchronous reset during WAIT, then a late drdy
        clear_logs(0);
        lat[0] = 20;
        resp_q[0].push_back(16'h7770);
        pulse_eoc(0);
        tick(3);
        check("arst_pre_busy", busy[0], 1'b1);
        #2;
        rst_n[0] = 1'b0;
        #1;
        check_zero(0, "arst");
        tick(2);
        rst_n[0] = 1'b1;
        nden = den_cyc[0].size();
        tick(30);
        check("arst_late_no_valid", vld_cnt[0], 0);
        check("arst_no_den", den_cyc[0].size(), nden);
        check("arst_idle", busy[0], 1'b0);
        resp_q[0].delete();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
